// File: rtl/exception_controller_if.sv
// Bundle between the writeback stage and the exception controller: exception
// requests, interrupt levels and masks, flush handshake, and vector outputs.
interface exception_controller_if;
    logic        UndefW;
    logic        SWIW;
    logic        PrefetchAbortW;
    logic        DataAbortW;
    logic        IRQ;
    logic        FIQ;
    logic        IBitW;
    logic        FBitW;
    logic [31:0] PCW;
    logic        FlushAckW;
    logic        FlushReqW;
    logic [6:0]  VectorAddressW;
    logic [31:0] LinkAddrW;
    logic [4:0]  NewModeW;
    logic        SetIW;
    logic        SetFW;
    logic        BusyW;

    // Pipeline side: raises requests, answers the flush handshake.
    modport master (
        output UndefW, SWIW, PrefetchAbortW, DataAbortW,
        output IRQ, FIQ, IBitW, FBitW, PCW, FlushAckW,
        input  FlushReqW, VectorAddressW, LinkAddrW, NewModeW,
        input  SetIW, SetFW, BusyW
    );

    // Controller side.
    modport slave (
        input  UndefW, SWIW, PrefetchAbortW, DataAbortW,
        input  IRQ, FIQ, IBitW, FBitW, PCW, FlushAckW,
        output FlushReqW, VectorAddressW, LinkAddrW, NewModeW,
        output SetIW, SetFW, BusyW
    );
endinterface

// File: rtl/exception_controller.sv
// Exception sequencer: prioritises writeback-stage exceptions and interrupts,
// flushes the pipeline, then presents a one-cycle vector with link and mode.
module exception_controller (
    input  logic                 clk,
    input  logic                 reset,
    exception_controller_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        IDLE   = 2'd1,
        FLUSH  = 2'd2,
        VECTOR = 2'd3
    } state_t;

    // Exception index doubles as the bit position in VectorAddressW.
    localparam logic [2:0] EXC_RESET = 3'd0;
    localparam logic [2:0] EXC_UNDEF = 3'd1;
    localparam logic [2:0] EXC_SWI   = 3'd2;
    localparam logic [2:0] EXC_PABT  = 3'd3;
    localparam logic [2:0] EXC_DABT  = 3'd4;
    localparam logic [2:0] EXC_IRQ   = 3'd5;
    localparam logic [2:0] EXC_FIQ   = 3'd6;

    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_FIQ = 5'b10001;

    function automatic logic [4:0] mode_of(input logic [2:0] idx);
        logic [4:0] m;
        case (idx)
            EXC_UNDEF: m = MODE_UND;
            EXC_SWI:   m = MODE_SVC;
            EXC_PABT:  m = MODE_ABT;
            EXC_DABT:  m = MODE_ABT;
            EXC_IRQ:   m = MODE_IRQ;
            EXC_FIQ:   m = MODE_FIQ;
            default:   m = MODE_SVC;
        endcase
        return m;
    endfunction

    // Data abort returns past the faulting instruction's prefetch slot.
    function automatic logic [31:0] link_of(input logic [2:0] idx, input logic [31:0] pc);
        logic [31:0] l;
        if (idx == EXC_DABT) begin
            l = pc + 32'd8;
        end else begin
            l = pc + 32'd4;
        end
        return l;
    endfunction

    function automatic logic [6:0] onehot_of(input logic [2:0] idx);
        logic [6:0] v;
        case (idx)
            EXC_RESET: v = 7'b0000001;
            EXC_UNDEF: v = 7'b0000010;
            EXC_SWI:   v = 7'b0000100;
            EXC_PABT:  v = 7'b0001000;
            EXC_DABT:  v = 7'b0010000;
            EXC_IRQ:   v = 7'b0100000;
            EXC_FIQ:   v = 7'b1000000;
            default:   v = 7'b0000000;
        endcase
        return v;
    endfunction

    state_t      state_r;
    logic        boot_armed_r;
    logic [3:0]  pending_r;
    logic [2:0]  exc_idx_r;
    logic [31:0] pc_r;
    logic [4:0]  mode_r;

    logic        flush_req_r;
    logic [6:0]  vector_r;
    logic [31:0] link_out_r;
    logic [4:0]  mode_out_r;
    logic        set_i_r;
    logic        set_f_r;
    logic        busy_r;

    // Bit order: 0 Undef, 1 SWI, 2 Prefetch Abort, 3 Data Abort.
    logic [3:0]  sync_req_s;
    logic [3:0]  eff_sync_s;
    logic        irq_eff_s;
    logic        fiq_eff_s;
    logic        any_req_s;
    logic [2:0]  win_idx_s;

    assign sync_req_s = {bus.DataAbortW, bus.PrefetchAbortW, bus.SWIW, bus.UndefW};
    assign eff_sync_s = pending_r | sync_req_s;
    assign irq_eff_s  = bus.IRQ & ~bus.IBitW;
    assign fiq_eff_s  = bus.FIQ & ~bus.FBitW;
    assign any_req_s  = (|eff_sync_s) | irq_eff_s | fiq_eff_s;

    // Fixed-priority winner selection among effective requests.
    always_comb begin
        win_idx_s = EXC_RESET;
        if (eff_sync_s[3]) begin
            win_idx_s = EXC_DABT;
        end else if (fiq_eff_s) begin
            win_idx_s = EXC_FIQ;
        end else if (irq_eff_s) begin
            win_idx_s = EXC_IRQ;
        end else if (eff_sync_s[2]) begin
            win_idx_s = EXC_PABT;
        end else if (eff_sync_s[0]) begin
            win_idx_s = EXC_UNDEF;
        end else if (eff_sync_s[1]) begin
            win_idx_s = EXC_SWI;
        end else begin
            win_idx_s = EXC_RESET;
        end
    end

    // Sequencer FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= BOOT;
            boot_armed_r <= 1'b1;
            pending_r    <= 4'd0;
            exc_idx_r    <= EXC_RESET;
            pc_r         <= 32'd0;
            mode_r       <= 5'd0;
            flush_req_r  <= 1'b0;
            vector_r     <= 7'd0;
            link_out_r   <= 32'd0;
            mode_out_r   <= 5'd0;
            set_i_r      <= 1'b0;
            set_f_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    // First post-reset edge shows the reset vector; the next leaves BOOT.
                    if (boot_armed_r) begin
                        boot_armed_r <= 1'b0;
                        vector_r     <= onehot_of(EXC_RESET);
                        link_out_r   <= 32'd0;
                        mode_out_r   <= MODE_SVC;
                        set_i_r      <= 1'b1;
                        set_f_r      <= 1'b1;
                        busy_r       <= 1'b1;
                        flush_req_r  <= 1'b0;
                    end else begin
                        state_r      <= IDLE;
                        vector_r     <= 7'd0;
                        link_out_r   <= 32'd0;
                        mode_out_r   <= 5'd0;
                        set_i_r      <= 1'b0;
                        set_f_r      <= 1'b0;
                        busy_r       <= 1'b0;
                        flush_req_r  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (any_req_s) begin
                        state_r     <= FLUSH;
                        exc_idx_r   <= win_idx_s;
                        pc_r        <= bus.PCW;
                        mode_r      <= mode_of(win_idx_s);
                        pending_r   <= 4'd0;
                        flush_req_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        pending_r   <= pending_r | sync_req_s;
                        flush_req_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (bus.FlushAckW) begin
                        state_r     <= VECTOR;
                        flush_req_r <= 1'b0;
                        vector_r    <= onehot_of(exc_idx_r);
                        link_out_r  <= link_of(exc_idx_r, pc_r);
                        mode_out_r  <= mode_r;
                        set_i_r     <= 1'b1;
                        set_f_r     <= (exc_idx_r == EXC_FIQ) || (exc_idx_r == EXC_RESET);
                        busy_r      <= 1'b1;
                    end else begin
                        flush_req_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                VECTOR: begin
                    state_r     <= IDLE;
                    vector_r    <= 7'd0;
                    link_out_r  <= 32'd0;
                    mode_out_r  <= 5'd0;
                    set_i_r     <= 1'b0;
                    set_f_r     <= 1'b0;
                    busy_r      <= 1'b0;
                    flush_req_r <= 1'b0;
                end
                default: begin
                    state_r      <= BOOT;
                    boot_armed_r <= 1'b1;
                    pending_r    <= 4'd0;
                    vector_r     <= 7'd0;
                    link_out_r   <= 32'd0;
                    mode_out_r   <= 5'd0;
                    set_i_r      <= 1'b0;
                    set_f_r      <= 1'b0;
                    busy_r       <= 1'b0;
                    flush_req_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.FlushReqW      = flush_req_r;
    assign bus.VectorAddressW = vector_r;
    assign bus.LinkAddrW      = link_out_r;
    assign bus.NewModeW       = mode_out_r;
    assign bus.SetIW          = set_i_r;
    assign bus.SetFW          = set_f_r;
    assign bus.BusyW          = busy_r;

endmodule

// File: tb/tb_exception_controller.sv
// Directed bench for exception_controller; expected vectors are queued as
// stimulus is applied and retired whenever the DUT presents a vector.
module tb_exception_controller;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    typedef struct packed {
        logic [6:0]  va;
        logic [31:0] link;
        logic [4:0]  mode;
        logic        seti;
        logic        setf;
    } exp_t;

    exp_t sb[$];

    exception_controller_if bus ();

    exception_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic expect_vec(input logic [6:0] va, input logic [31:0] link,
                              input logic [4:0] mode, input logic setf);
        exp_t e;
        e.va   = va;
        e.link = link;
        e.mode = mode;
        e.seti = 1'b1;
        e.setf = setf;
        sb.push_back(e);
    endtask

    task automatic observe();
        exp_t e;
        check("vector_onehot0", 64'($onehot0(bus.VectorAddressW)), 64'd1);
        if (bus.VectorAddressW != 7'd0) begin
            if (sb.size() == 0) begin
                check("unexpected_vector", 64'(bus.VectorAddressW), 64'd0);
            end else begin
                e = sb.pop_front();
                check("vec_addr", 64'(bus.VectorAddressW), 64'(e.va));
                check("vec_link", 64'(bus.LinkAddrW), 64'(e.link));
                check("vec_mode", 64'(bus.NewModeW), 64'(e.mode));
                check("vec_seti", 64'(bus.SetIW), 64'(e.seti));
                check("vec_setf", 64'(bus.SetFW), 64'(e.setf));
                check("vec_busy", 64'(bus.BusyW), 64'd1);
                check("vec_noflush", 64'(bus.FlushReqW), 64'd0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        observe();
    endtask

    // All seven outputs packed into one word for quiet-state checks.
    function automatic logic [63:0] outs();
        return {15'd0, bus.FlushReqW, bus.VectorAddressW, bus.LinkAddrW,
                bus.NewModeW, bus.SetIW, bus.SetFW, bus.BusyW};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.UndefW = 1'b0; bus.SWIW = 1'b0; bus.PrefetchAbortW = 1'b0; bus.DataAbortW = 1'b0;
        bus.IRQ = 1'b0; bus.FIQ = 1'b0; bus.IBitW = 1'b0; bus.FBitW = 1'b0;
        bus.PCW = 32'd0; bus.FlushAckW = 1'b1;

        // Reset: outputs quiet, then boot vector, then idle.
        step(); step(); step();
        check("reset_outputs", outs(), 64'd0);
        reset = 1'b0;
        expect_vec(7'h01, 32'd0, 5'b10011, 1'b1);
        step();
        check("boot_busy", 64'(bus.BusyW), 64'd1);
        step();
        check("post_boot_idle", outs(), 64'd0);

        // SWI with immediate flush ack.
        bus.PCW = 32'h100; bus.SWIW = 1'b1;
        expect_vec(7'h04, 32'h104, 5'b10011, 1'b0);
        step();
        bus.SWIW = 1'b0;
        check("swi_flushreq", 64'(bus.FlushReqW), 64'd1);
        check("swi_flush_novec", 64'(bus.VectorAddressW), 64'd0);
        step();
        step();
        check("swi_idle_busy", 64'(bus.BusyW), 64'd0);

        // Data abort beats Undef in the same cycle; Undef is dropped.
        bus.PCW = 32'h200; bus.DataAbortW = 1'b1; bus.UndefW = 1'b1;
        expect_vec(7'h10, 32'h208, 5'b10111, 1'b0);
        step();
        bus.DataAbortW = 1'b0; bus.UndefW = 1'b0;
        step(); step(); step(); step();
        check("dabt_undef_dropped", outs(), 64'd0);

        // Masked IRQ is ignored; unmasking takes it.
        bus.PCW = 32'h300; bus.IRQ = 1'b1; bus.IBitW = 1'b1;
        step(); step(); step();
        check("irq_masked", outs(), 64'd0);
        bus.IBitW = 1'b0;
        expect_vec(7'h20, 32'h304, 5'b10010, 1'b0);
        step();
        bus.IRQ = 1'b0;
        check("irq_flushreq", 64'(bus.FlushReqW), 64'd1);
        step(); step();

        // FIQ wins over IRQ and sets F.
        bus.PCW = 32'h400; bus.IRQ = 1'b1; bus.FIQ = 1'b1;
        expect_vec(7'h40, 32'h404, 5'b10001, 1'b1);
        step();
        bus.IRQ = 1'b0; bus.FIQ = 1'b0;
        step(); step();
        check("fiq_done_idle", outs(), 64'd0);

        // Priority among synchronous requests: Prefetch > Undef > SWI.
        bus.PCW = 32'h480; bus.PrefetchAbortW = 1'b1; bus.UndefW = 1'b1; bus.SWIW = 1'b1;
        expect_vec(7'h08, 32'h484, 5'b10111, 1'b0);
        step();
        bus.PrefetchAbortW = 1'b0; bus.UndefW = 1'b0; bus.SWIW = 1'b0;
        step(); step(); step();

        // Data abort beats FIQ; FIQ level still high is taken back in IDLE.
        bus.PCW = 32'h700; bus.DataAbortW = 1'b1; bus.FIQ = 1'b1;
        expect_vec(7'h10, 32'h708, 5'b10111, 1'b0);
        step();
        bus.DataAbortW = 1'b0;
        step(); step();
        expect_vec(7'h40, 32'h704, 5'b10001, 1'b1);
        step();
        bus.FIQ = 1'b0;
        check("fiq_reeval_flush", 64'(bus.FlushReqW), 64'd1);
        step(); step();

        // Flush stall of two cycles, then ack.
        bus.FlushAckW = 1'b0; bus.PCW = 32'h600; bus.PrefetchAbortW = 1'b1;
        expect_vec(7'h08, 32'h604, 5'b10111, 1'b0);
        step();
        bus.PrefetchAbortW = 1'b0;
        step();
        check("stall_flushreq", 64'(bus.FlushReqW), 64'd1);
        bus.FlushAckW = 1'b1;
        step(); step();

        // Flush stall of five cycles interrupted by reset.
        bus.FlushAckW = 1'b0; bus.PCW = 32'h500; bus.PrefetchAbortW = 1'b1;
        step();
        bus.PrefetchAbortW = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall5_flushreq", 64'(bus.FlushReqW), 64'd1);
            check("stall5_novec", 64'(bus.VectorAddressW), 64'd0);
            step();
        end
        reset = 1'b1;
        step();
        check("midflush_reset_outputs", outs(), 64'd0);
        bus.FlushAckW = 1'b1;
        step();
        check("midflush_reset_hold", outs(), 64'd0);
        reset = 1'b0;
        expect_vec(7'h01, 32'd0, 5'b10011, 1'b1);
        step();
        step();
        check("reboot_idle", outs(), 64'd0);

        // Link address wraps modulo 2^32.
        bus.PCW = 32'hFFFFFFFC; bus.UndefW = 1'b1;
        expect_vec(7'h02, 32'h00000000, 5'b11011, 1'b0);
        step();
        bus.UndefW = 1'b0;
        step(); step(); step();
        check("final_idle", outs(), 64'd0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exception_controller.md
EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports UndefW, SWIW, PrefetchAbortW, DataAbortW, each input, 1, single-cycle synchronous exception requests from the writeback stage.
REQ-004 SHALL have ports IRQ, FIQ, input, 1, level interrupt requests, already synchronised to clk.
REQ-005 SHALL have ports IBitW, FBitW, input, 1, CPSR interrupt mask bits; 1 = masked.
REQ-006 SHALL have port PCW, input, 32, address of the instruction in writeback.
REQ-007 SHALL have port FlushAckW, input, 1, pipeline reports drain complete.
REQ-008 SHALL have port FlushReqW, output, 1, request to flush all stages.
REQ-009 SHALL have port VectorAddressW, output, 7, one-hot exception select: bit 0 Reset, 1 Undef, 2 SWI, 3 Prefetch Abort, 4 Data Abort, 5 IRQ, 6 FIQ.
REQ-010 SHALL have ports LinkAddrW, output, 32, and NewModeW, output, 5, giving the banked LR value and the target CPSR mode.
REQ-011 SHALL have ports SetIW, SetFW, BusyW, output, 1: mask-set strobes and not-idle flag.

Function
REQ-012 SHALL implement states BOOT, IDLE, FLUSH, VECTOR.
REQ-013 BOOT SHALL last exactly one cycle and drive VectorAddressW=7'b0000001, NewModeW=5'b10011, SetIW=1, SetFW=1, LinkAddrW=0; next state IDLE.
REQ-014 IDLE SHALL OR the four synchronous request inputs into a 4-bit pending register each cycle.
REQ-015 Effective requests: pending bits, the same-cycle synchronous inputs, IRQ&~IBitW, FIQ&~FBitW.
REQ-016 Priority, highest first: Data Abort, FIQ, IRQ, Prefetch Abort, Undef, SWI.
REQ-017 In IDLE with any effective request, SHALL latch the winning index, PCW, and the computed link/mode, then go to FLUSH next cycle.
REQ-018 On entering FLUSH SHALL clear all pending bits; losing synchronous requests are discarded.
REQ-019 FLUSH SHALL hold FlushReqW=1 until FlushAckW is sampled 1; next state VECTOR.
REQ-020 Selection SHALL be frozen in FLUSH; request inputs arriving in FLUSH or VECTOR SHALL be ignored, except level interrupts re-evaluated in IDLE.
REQ-021 VECTOR SHALL last one cycle, drive the latched one-hot VectorAddressW, LinkAddrW, NewModeW, SetIW=1, and SetFW=1 only for FIQ or Reset; next state IDLE.
REQ-022 Outside BOOT/VECTOR, VectorAddressW SHALL be 0 and SetIW=SetFW=0; LinkAddrW, NewModeW SHALL be 0.
REQ-023 LinkAddrW = latched PCW+8 for Data Abort, PCW+4 for all others; 32-bit modulo wrap (PCW=32'hFFFFFFFC gives +4 = 0).
REQ-024 NewModeW: Undef 11011, SWI 10011, Prefetch/Data Abort 10111, IRQ 10010, FIQ 10001.
REQ-025 BusyW SHALL be 1 in BOOT, FLUSH, VECTOR; 0 in IDLE.
REQ-026 Minimum latency: request at cycle N, FlushReqW at N+1; FlushAckW=1 at N+1 yields VectorAddressW at N+2.
REQ-027 VectorAddressW SHALL never have more than one bit set.

Reset
REQ-028 reset=1 at a clock edge SHALL put the block in BOOT, clear pending and latched registers, from any state including FLUSH mid-handshake.
REQ-029 While reset=1 all outputs SHALL be 0; BOOT outputs appear in the first cycle after reset deasserts.

Verification
REQ-030 Release reset -> next cycle VectorAddressW=7'h01, NewModeW=10011, SetIW=SetFW=1; following cycle BusyW=0.
REQ-031 SWIW pulse, PCW=32'h100, FlushAckW tied 1 -> FlushReqW next cycle, then VectorAddressW=7'h04, LinkAddrW=32'h104, NewModeW=10011, SetFW=0.
REQ-032 DataAbortW and UndefW same cycle, PCW=32'h200 -> VectorAddressW=7'h10, LinkAddrW=32'h208, Undef discarded (no second vector).
REQ-033 IRQ=1 with IBitW=1 -> no FlushReqW; drop IBitW -> VectorAddressW=7'h20, NewModeW=10010; FIQ and IRQ together unmasked -> 7'h40, SetFW=1.
REQ-034 FlushAckW held 0 for 5 cycles -> FlushReqW=1 for all 5, VectorAddressW=0; asserting reset during this -> BOOT vector after release.
REQ-035 Undef with PCW=32'hFFFFFFFC -> LinkAddrW=32'h00000000.
